dbgapb_arb: RTL and testbench
=============================

// Module: dbgapb_arb
// PURPOSE
// Two-requester arbiter for the single debug APB port of cpu_wrap (dbg_p*).
// Requester 0 is the JTAG/DTM bridge; requester 1 is the host/bench APB driver.
// The arbiter serialises their transfers onto one APB master with round-robin
// grant, and gives every transfer a timeout so a hung debug slave cannot lock either requester.
// PARAMETERS
// ADDR_WIDTH  32    APB address width
// DATA_WIDTH  32    APB data width; pstrb width = DATA_WIDTH/8
// TIMEOUT     1024  max ACCESS cycles waiting m_pready; 0 disables timeout
// PORTS
// clk                in   1      clock
// rstn               in   1      synchronous active-low reset
// sN_psel (N=0,1)    in   1      requester N select
// sN_penable         in   1      requester N enable
// sN_paddr           in   ADDR   requester N address
// sN_pwrite          in   1      requester N write
// sN_pstrb           in   DW/8   requester N byte strobes
// sN_pprot           in   3      requester N protection
// sN_pwdata          in   DW     requester N write data
// sN_prdata          out  DW     read data returned to requester N
// sN_pslverr         out  1      error returned to requester N
// sN_pready          out  1      transfer complete to requester N
// m_psel/m_penable   out  1      to dbg_psel/dbg_penable
// m_paddr/m_pwrite/m_pstrb/m_pprot/m_pwdata  out  (as sN_)  to dbg_p*
// m_prdata           in   DW     from dbg_prdata
// m_pslverr          in   1      from dbg_pslverr
// m_pready           in   1      from dbg_pready
// gnt                out  1      index of granted requester
// timeout_evt        out  1      1-cycle pulse on transfer abort by timeout
// BEHAVIOUR
// - Reset: state IDLE, gnt=0, last=1 (s0 wins first tie), m_psel=m_penable=0,
//   sN_pready=0, sN_pslverr=0, sN_prdata=0, timeout_evt=0, wait counter=0.
// - FSM states IDLE, SETUP, ACCESS; state, gnt and last are registered.
// - IDLE: request = sN_psel=1 (penable ignored). If exactly one requests, grant it.
//   If both request, grant ~last. Go to SETUP and load gnt.
// - SETUP: m_psel=1, m_penable=0. Always go to ACCESS next cycle.
// - ACCESS: m_psel=1, m_penable=1. Wait counter increments each cycle.
// - Transfer completion in ACCESS when m_pready=1:
//   - s[gnt]_pready=1, s[gnt]_prdata=m_prdata, s[gnt]_pslverr=m_pslverr, combinational in the same cycle.
//   - last<=gnt; counter clears.
//   - Next state is SETUP with the other requester if its psel=1; otherwise IDLE.
//   - The completing requester is never re-sampled in its own completion cycle, so it is not re-granted then.
// - Timeout (TIMEOUT>0) when the counter reaches TIMEOUT-1 with m_pready=0:
//   - s[gnt]_pready=1, pslverr=1, prdata=0.
//   - timeout_evt=1 for that cycle; last<=gnt.
//   - m_psel drops next cycle; next state follows the same rule as completion.
// - m_paddr/pwrite/pstrb/pprot/pwdata are muxed combinationally from s[gnt] in every state.
//   The values are only meaningful while m_psel=1.
// - The non-granted requester sees pready=0 for as long as it waits. Its prdata/pslverr are 0.
// - Latency: request seen in IDLE at cycle T gives m_psel at T+1 and m_penable at T+2.
//   With a zero-wait slave, sN_pready=1 at T+2, i.e. one extra wait cycle vs a direct connection.
// - Granted requester drops psel before completion (protocol violation): the master
//   transfer still completes normally. The returned pready/data is discarded.
// - Counter width is $clog2(TIMEOUT+1). With TIMEOUT=0 the counter is held at 0 and never fires.
// - Reset mid-transfer: next edge forces IDLE; m_psel=0 with no completion returned.
// TESTING
// - s0 write 0x0400_0000=0x1, zero-wait slave -> m_psel at T+1, m_penable at T+2,
//   s0_pready at T+2, s1_pready held 0.
// - s0 and s1 request in the same cycle, repeatedly -> grants alternate 0,1,0,1;
//   the first grant is 0; no idle cycle between master transfers.
// - s1 read, slave pready after 3 waits with prdata=0xA5A5_0001, pslverr=1
//   -> s1 gets the same data and pslverr on the completion cycle.
// - TIMEOUT=8, slave never readies -> after 8 ACCESS cycles: s0_pready=1,
//   pslverr=1, prdata=0, timeout_evt pulse; the next s1 request is granted.
// - rstn low during ACCESS -> next cycle IDLE, m_psel=0, gnt=0.
//   The first request after reset goes to s0.
// - s0 back-to-back transfers while s1 is pending -> s1 is granted between s0's two transfers.

Source files
------------

// File: rtl/dbgapb_arb.sv
// dbgapb_arb: round-robin arbiter that serialises two APB requesters onto the single
// debug APB master port, with a per-transfer ACCESS-phase timeout.
module dbgapb_arb #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 1024
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic                      s0_psel,
    input  logic                      s0_penable,
    input  logic [ADDR_WIDTH-1:0]     s0_paddr,
    input  logic                      s0_pwrite,
    input  logic [DATA_WIDTH/8-1:0]   s0_pstrb,
    input  logic [2:0]                s0_pprot,
    input  logic [DATA_WIDTH-1:0]     s0_pwdata,
    output logic [DATA_WIDTH-1:0]     s0_prdata,
    output logic                      s0_pslverr,
    output logic                      s0_pready,
    input  logic                      s1_psel,
    input  logic                      s1_penable,
    input  logic [ADDR_WIDTH-1:0]     s1_paddr,
    input  logic                      s1_pwrite,
    input  logic [DATA_WIDTH/8-1:0]   s1_pstrb,
    input  logic [2:0]                s1_pprot,
    input  logic [DATA_WIDTH-1:0]     s1_pwdata,
    output logic [DATA_WIDTH-1:0]     s1_prdata,
    output logic                      s1_pslverr,
    output logic                      s1_pready,
    output logic                      m_psel,
    output logic                      m_penable,
    output logic [ADDR_WIDTH-1:0]     m_paddr,
    output logic                      m_pwrite,
    output logic [DATA_WIDTH/8-1:0]   m_pstrb,
    output logic [2:0]                m_pprot,
    output logic [DATA_WIDTH-1:0]     m_pwdata,
    input  logic [DATA_WIDTH-1:0]     m_prdata,
    input  logic                      m_pslverr,
    input  logic                      m_pready,
    output logic                      gnt,
    output logic                      timeout_evt
);

    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : {CW{1'b0}};

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic            r_gnt;
    logic            w_gnt_nxt;
    logic            r_last;
    logic            w_last_nxt;
    logic [CW-1:0]   r_cnt;
    logic [CW-1:0]   w_cnt_nxt;
    logic            w_in_access;
    logic            w_done;
    logic            w_to;
    logic            w_other_psel;
    logic            w_unused_penable;

    // Requesters' penable carries no information the arbiter needs; psel alone is the request.
    assign w_unused_penable = s0_penable ^ s1_penable;

    // Completion and timeout are suppressed while reset is asserted so an aborted transfer returns nothing.
    assign w_in_access  = (r_state == ST_ACCESS);
    assign w_done       = rstn && w_in_access && m_pready;
    assign w_to         = rstn && w_in_access && !m_pready && (TIMEOUT > 0) && (r_cnt == CNT_LAST);
    assign w_other_psel = r_gnt ? s0_psel : s1_psel;

    // State, grant, round-robin pointer and ACCESS wait counter.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state <= ST_IDLE;
            r_gnt   <= 1'b0;
            r_last  <= 1'b1;
            r_cnt   <= CNT_ZERO;
        end else begin
            r_state <= w_state_nxt;
            r_gnt   <= w_gnt_nxt;
            r_last  <= w_last_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Next-state, grant selection and wait-counter update.
    always_comb begin
        w_state_nxt = r_state;
        w_gnt_nxt   = r_gnt;
        w_last_nxt  = r_last;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            ST_IDLE: begin
                w_cnt_nxt = CNT_ZERO;
                if (s0_psel && s1_psel) begin
                    w_state_nxt = ST_SETUP;
                    w_gnt_nxt   = ~r_last;
                end else if (s0_psel || s1_psel) begin
                    w_state_nxt = ST_SETUP;
                    w_gnt_nxt   = s1_psel;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_SETUP: begin
                w_state_nxt = ST_ACCESS;
                w_cnt_nxt   = CNT_ZERO;
            end
            ST_ACCESS: begin
                // The finishing requester is not re-sampled here; only the other one can follow directly.
                if (w_done || w_to) begin
                    w_last_nxt = r_gnt;
                    w_cnt_nxt  = CNT_ZERO;
                    if (w_other_psel) begin
                        w_state_nxt = ST_SETUP;
                        w_gnt_nxt   = ~r_gnt;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end else if (TIMEOUT > 0) begin
                    w_cnt_nxt = r_cnt + CNT_ONE;
                end else begin
                    w_cnt_nxt = CNT_ZERO;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = CNT_ZERO;
            end
        endcase
    end

    // Master-side phase signals and request-field mux from the granted requester.
    always_comb begin
        m_psel      = (r_state != ST_IDLE);
        m_penable   = (r_state == ST_ACCESS);
        gnt         = r_gnt;
        timeout_evt = w_to;
        if (r_gnt) begin
            m_paddr  = s1_paddr;
            m_pwrite = s1_pwrite;
            m_pstrb  = s1_pstrb;
            m_pprot  = s1_pprot;
            m_pwdata = s1_pwdata;
        end else begin
            m_paddr  = s0_paddr;
            m_pwrite = s0_pwrite;
            m_pstrb  = s0_pstrb;
            m_pprot  = s0_pprot;
            m_pwdata = s0_pwdata;
        end
    end

    // Response routing: only the granted requester sees pready; a timeout returns an error with zero data.
    always_comb begin
        s0_pready  = 1'b0;
        s0_prdata  = {DATA_WIDTH{1'b0}};
        s0_pslverr = 1'b0;
        s1_pready  = 1'b0;
        s1_prdata  = {DATA_WIDTH{1'b0}};
        s1_pslverr = 1'b0;
        if (w_done) begin
            if (r_gnt) begin
                s1_pready  = 1'b1;
                s1_prdata  = m_prdata;
                s1_pslverr = m_pslverr;
            end else begin
                s0_pready  = 1'b1;
                s0_prdata  = m_prdata;
                s0_pslverr = m_pslverr;
            end
        end else if (w_to) begin
            if (r_gnt) begin
                s1_pready  = 1'b1;
                s1_pslverr = 1'b1;
            end else begin
                s0_pready  = 1'b1;
                s0_pslverr = 1'b1;
            end
        end else begin
            s0_pready = 1'b0;
            s1_pready = 1'b0;
        end
    end

endmodule

// File: tb/tb_dbgapb_arb.sv
// Scoreboard bench for dbgapb_arb: requester tasks push expected responses, a negedge
// monitor pops and compares on every pready and every master SETUP phase.
module tb_dbgapb_arb;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rstn;
    logic          s0_psel, s0_penable, s0_pwrite, s0_pslverr, s0_pready;
    logic [AW-1:0] s0_paddr;
    logic [3:0]    s0_pstrb;
    logic [2:0]    s0_pprot;
    logic [DW-1:0] s0_pwdata, s0_prdata;
    logic          s1_psel, s1_penable, s1_pwrite, s1_pslverr, s1_pready;
    logic [AW-1:0] s1_paddr;
    logic [3:0]    s1_pstrb;
    logic [2:0]    s1_pprot;
    logic [DW-1:0] s1_pwdata, s1_prdata;
    logic          m_psel, m_penable, m_pwrite, m_pslverr, m_pready;
    logic [AW-1:0] m_paddr;
    logic [3:0]    m_pstrb;
    logic [2:0]    m_pprot;
    logic [DW-1:0] m_pwdata, m_prdata;
    logic          gnt, timeout_evt;

    dbgapb_arb #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
        .clk(clk), .rstn(rstn),
        .s0_psel(s0_psel), .s0_penable(s0_penable), .s0_paddr(s0_paddr), .s0_pwrite(s0_pwrite),
        .s0_pstrb(s0_pstrb), .s0_pprot(s0_pprot), .s0_pwdata(s0_pwdata),
        .s0_prdata(s0_prdata), .s0_pslverr(s0_pslverr), .s0_pready(s0_pready),
        .s1_psel(s1_psel), .s1_penable(s1_penable), .s1_paddr(s1_paddr), .s1_pwrite(s1_pwrite),
        .s1_pstrb(s1_pstrb), .s1_pprot(s1_pprot), .s1_pwdata(s1_pwdata),
        .s1_prdata(s1_prdata), .s1_pslverr(s1_pslverr), .s1_pready(s1_pready),
        .m_psel(m_psel), .m_penable(m_penable), .m_paddr(m_paddr), .m_pwrite(m_pwrite),
        .m_pstrb(m_pstrb), .m_pprot(m_pprot), .m_pwdata(m_pwdata),
        .m_prdata(m_prdata), .m_pslverr(m_pslverr), .m_pready(m_pready),
        .gnt(gnt), .timeout_evt(timeout_evt)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
        logic        to;
    } resp_t;

    typedef struct packed {
        logic        g;
        logic [31:0] addr;
        logic        wr;
        logic [31:0] wdata;
    } mreq_t;

    resp_t q0[$];
    resp_t q1[$];
    mreq_t mq[$];

    // Slave model: ready after slv_waits ACCESS cycles, never while hung.
    logic        slv_hang;
    int          slv_waits;
    logic [31:0] slv_rdata;
    logic        slv_err;
    int          acc_cnt;

    always @(posedge clk) begin
        if (m_psel && m_penable && !m_pready) acc_cnt <= acc_cnt + 1;
        else acc_cnt <= 0;
    end
    assign m_pready  = m_psel && m_penable && !slv_hang && (acc_cnt == slv_waits);
    assign m_prdata  = slv_rdata;
    assign m_pslverr = slv_err;

    logic win;
    int   w_hi, w_en, w_first, w_last;

    // Monitor: counts window activity, scores requester responses and master SETUP phases.
    always @(negedge clk) begin : mon
        resp_t r;
        mreq_t m;
        cyc++;
        if (win) begin
            if (m_psel === 1'b1) begin
                if (w_first < 0) w_first = cyc;
                w_last = cyc;
                w_hi++;
            end
            if (m_penable === 1'b1) w_en++;
        end
        if (s0_pready === 1'b1 || s1_pready === 1'b1)
            check("pready_onehot", 64'(s0_pready & s1_pready), 64'd0);
        if (s0_pready === 1'b1) begin
            if (q0.size() == 0) begin
                n_checks++; n_fail++;
                $display("FAIL s0_unexpected_pready: got 1 expected 0 (cycle %0d)", cyc);
            end else begin
                r = q0.pop_front();
                check("s0_prdata", 64'(s0_prdata), 64'(r.rdata));
                check("s0_pslverr", 64'(s0_pslverr), 64'(r.err));
                check("s0_timeout_evt", 64'(timeout_evt), 64'(r.to));
                check("s1_quiet_resp", 64'({s1_prdata, s1_pslverr}), 64'd0);
            end
        end
        if (s1_pready === 1'b1) begin
            if (q1.size() == 0) begin
                n_checks++; n_fail++;
                $display("FAIL s1_unexpected_pready: got 1 expected 0 (cycle %0d)", cyc);
            end else begin
                r = q1.pop_front();
                check("s1_prdata", 64'(s1_prdata), 64'(r.rdata));
                check("s1_pslverr", 64'(s1_pslverr), 64'(r.err));
                check("s1_timeout_evt", 64'(timeout_evt), 64'(r.to));
                check("s0_quiet_resp", 64'({s0_prdata, s0_pslverr}), 64'd0);
            end
        end
        if (timeout_evt === 1'b1 && s0_pready !== 1'b1 && s1_pready !== 1'b1) begin
            n_checks++; n_fail++;
            $display("FAIL timeout_evt_alone: got 1 expected 0 (cycle %0d)", cyc);
        end
        if (m_psel === 1'b1 && m_penable === 1'b0) begin
            if (mq.size() == 0) begin
                n_checks++; n_fail++;
                $display("FAIL m_unexpected_setup: got gnt %0d expected none (cycle %0d)", gnt, cyc);
            end else begin
                m = mq.pop_front();
                check("m_gnt", 64'(gnt), 64'(m.g));
                check("m_paddr", 64'(m_paddr), 64'(m.addr));
                check("m_pwrite", 64'(m_pwrite), 64'(m.wr));
                check("m_pwdata", 64'(m_pwdata), 64'(m.wdata));
                check("m_pprot", 64'(m_pprot), m.g ? 64'd2 : 64'd1);
                check("m_pstrb", 64'(m_pstrb), m.g ? 64'd3 : 64'd15);
            end
        end
    end

    // One APB transfer from requester id; entered and left at posedge+1.
    task automatic xfer(input int id, input logic [31:0] addr, input logic wr,
                        input logic [31:0] wdata, input resp_t er);
        logic got;
        if (id == 0) begin
            q0.push_back(er);
            s0_psel = 1'b1; s0_penable = 1'b0; s0_paddr = addr; s0_pwrite = wr;
            s0_pwdata = wdata; s0_pstrb = 4'hF; s0_pprot = 3'd1;
        end else begin
            q1.push_back(er);
            s1_psel = 1'b1; s1_penable = 1'b0; s1_paddr = addr; s1_pwrite = wr;
            s1_pwdata = wdata; s1_pstrb = 4'h3; s1_pprot = 3'd2;
        end
        @(posedge clk); #1;
        if (id == 0) s0_penable = 1'b1;
        else s1_penable = 1'b1;
        got = 1'b0;
        for (int k = 0; k < 40 && !got; k++) begin
            @(negedge clk);
            if ((id == 0) ? s0_pready : s1_pready) got = 1'b1;
            else @(posedge clk);
        end
        check($sformatf("s%0d_req_completed", id), 64'(got), 64'd1);
        @(posedge clk); #1;
        if (id == 0) begin s0_psel = 1'b0; s0_penable = 1'b0; end
        else begin s1_psel = 1'b0; s1_penable = 1'b0; end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic win_start();
        w_hi = 0; w_en = 0; w_first = -1; w_last = -1; win = 1'b1;
    endtask

    // Watchdog so the bench always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    // Directed stimulus sequence.
    initial begin
        resp_t ok;
        rstn = 1'b0;
        s0_psel = 1'b0; s0_penable = 1'b0; s0_paddr = '0; s0_pwrite = 1'b0; s0_pstrb = '0; s0_pprot = '0; s0_pwdata = '0;
        s1_psel = 1'b0; s1_penable = 1'b0; s1_paddr = '0; s1_pwrite = 1'b0; s1_pstrb = '0; s1_pprot = '0; s1_pwdata = '0;
        slv_hang = 1'b0; slv_waits = 0; slv_rdata = 32'h0; slv_err = 1'b0;
        win = 1'b0; w_hi = 0; w_en = 0; w_first = -1; w_last = -1;

        // Reset state.
        idle(3);
        check("rst_m_psel", 64'(m_psel), 64'd0);
        check("rst_m_penable", 64'(m_penable), 64'd0);
        check("rst_gnt", 64'(gnt), 64'd0);
        check("rst_pready", 64'({s0_pready, s1_pready}), 64'd0);
        check("rst_resp", 64'({s0_prdata, s0_pslverr, s1_pslverr}), 64'd0);
        check("rst_timeout_evt", 64'(timeout_evt), 64'd0);
        rstn = 1'b1;
        idle(2);

        // s0 write with zero-wait slave: latency T+1 / T+2.
        mq.push_back('{1'b0, 32'h0400_0000, 1'b1, 32'h1});
        fork
            xfer(0, 32'h0400_0000, 1'b1, 32'h1, '{32'h0, 1'b0, 1'b0});
            begin
                @(negedge clk);
                check("t1_m_psel_T", 64'(m_psel), 64'd0);
                @(negedge clk);
                check("t1_m_psel_T1", 64'({m_psel, m_penable}), 64'd2);
                check("t1_s0_pready_T1", 64'(s0_pready), 64'd0);
                @(negedge clk);
                check("t1_m_penable_T2", 64'({m_psel, m_penable}), 64'd3);
                check("t1_s0_pready_T2", 64'(s0_pready), 64'd1);
                check("t1_s1_pready_T2", 64'(s1_pready), 64'd0);
            end
        join
        idle(2);

        // s1 read, slave ready after 3 waits with error.
        slv_waits = 3; slv_rdata = 32'hA5A5_0001; slv_err = 1'b1;
        mq.push_back('{1'b1, 32'h0000_0010, 1'b0, 32'h0});
        win_start();
        xfer(1, 32'h0000_0010, 1'b0, 32'h0, '{32'hA5A5_0001, 1'b1, 1'b0});
        win = 1'b0;
        check("t3_access_cycles", 64'(w_en), 64'd4);
        idle(2);

        // Simultaneous repeated requests alternate 0,1,0,1 with no master idle cycle.
        slv_waits = 0; slv_rdata = 32'h1234_5678; slv_err = 1'b0;
        ok = '{32'h1234_5678, 1'b0, 1'b0};
        mq.push_back('{1'b0, 32'h100, 1'b1, 32'hA0});
        mq.push_back('{1'b1, 32'h200, 1'b1, 32'hB0});
        mq.push_back('{1'b0, 32'h104, 1'b1, 32'hA1});
        mq.push_back('{1'b1, 32'h204, 1'b1, 32'hB1});
        win_start();
        fork
            begin xfer(0, 32'h100, 1'b1, 32'hA0, ok); xfer(0, 32'h104, 1'b1, 32'hA1, ok); end
            begin xfer(1, 32'h200, 1'b1, 32'hB0, ok); xfer(1, 32'h204, 1'b1, 32'hB1, ok); end
        join
        win = 1'b0;
        check("t4_psel_cycles", 64'(w_hi), 64'd8);
        check("t4_no_gap", 64'(w_last - w_first + 1), 64'd8);
        idle(2);

        // s0 back-to-back while s1 pending: s1 slots in between.
        mq.push_back('{1'b0, 32'h300, 1'b0, 32'h0});
        mq.push_back('{1'b1, 32'h400, 1'b0, 32'h0});
        mq.push_back('{1'b0, 32'h304, 1'b0, 32'h0});
        fork
            begin xfer(0, 32'h300, 1'b0, 32'h0, ok); xfer(0, 32'h304, 1'b0, 32'h0, ok); end
            begin @(posedge clk); #1; xfer(1, 32'h400, 1'b0, 32'h0, ok); end
        join
        idle(2);

        // Timeout: hung slave, abort after 8 ACCESS cycles, then s1 is served.
        slv_hang = 1'b1;
        mq.push_back('{1'b0, 32'h500, 1'b1, 32'hDEAD});
        win_start();
        xfer(0, 32'h500, 1'b1, 32'hDEAD, '{32'h0, 1'b1, 1'b1});
        win = 1'b0;
        check("t6_access_cycles", 64'(w_en), 64'd8);
        slv_hang = 1'b0;
        idle(1);
        check("t6_psel_dropped", 64'(m_psel), 64'd0);
        mq.push_back('{1'b1, 32'h600, 1'b0, 32'h0});
        xfer(1, 32'h600, 1'b0, 32'h0, ok);
        mq.push_back('{1'b0, 32'h700, 1'b0, 32'h0});
        xfer(0, 32'h700, 1'b0, 32'h0, ok);
        idle(2);

        // Reset during s1 ACCESS: IDLE, no completion; first tie afterwards goes to s0.
        slv_hang = 1'b1;
        mq.push_back('{1'b1, 32'h800, 1'b0, 32'h0});
        s1_psel = 1'b1; s1_penable = 1'b0; s1_paddr = 32'h800; s1_pwrite = 1'b0;
        s1_pwdata = 32'h0; s1_pstrb = 4'h3; s1_pprot = 3'd2;
        @(posedge clk); #1;
        s1_penable = 1'b1;
        idle(2);
        check("t7_in_access", 64'({m_psel, m_penable, gnt}), 64'd7);
        rstn = 1'b0; s1_psel = 1'b0; s1_penable = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("t7_rst_m_psel", 64'({m_psel, m_penable}), 64'd0);
        check("t7_rst_gnt", 64'(gnt), 64'd0);
        check("t7_rst_no_resp", 64'(s1_pready), 64'd0);
        @(posedge clk); #1;
        rstn = 1'b1; slv_hang = 1'b0;
        idle(1);
        mq.push_back('{1'b0, 32'h900, 1'b1, 32'h9});
        mq.push_back('{1'b1, 32'hA00, 1'b1, 32'hA});
        fork
            xfer(0, 32'h900, 1'b1, 32'h9, ok);
            xfer(1, 32'hA00, 1'b1, 32'hA, ok);
        join
        idle(3);

        check("sb_q0_empty", 64'(q0.size()), 64'd0);
        check("sb_q1_empty", 64'(q1.size()), 64'd0);
        check("sb_mq_empty", 64'(mq.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
